// File: rtl/gol_timing_pkg.sv
// Shared timing definitions for the generation-tick path of the Game of Life engine.
package gol_timing_pkg;

    // Receiver tracking state: waiting for a first edge, measuring, or source lost.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALLED = 2'd2
    } rx_state_e;

    // Rejected-edge counter width and the value it sticks at.
    localparam int                  GLITCH_W   = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    // Saturating increment for the glitch counter.
    function automatic logic [GLITCH_W-1:0] glitch_inc(input logic [GLITCH_W-1:0] value);
        return (value == GLITCH_MAX) ? value : value + GLITCH_W'(1);
    endfunction

endpackage

// File: rtl/gen_tick_receiver_sync_edge_detect.sv
// Three-flop synchronizer for an asynchronous level, with a rising-edge strobe
// taken from the two settled stages.
module sync_edge_detect (
    input  logic clock_in,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Shift the asynchronous level through three flops; s1 absorbs metastability.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Rising edge seen between the two stable stages.
    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/gen_tick_receiver.sv
// Receives the divided slow clock, turns its rising edges into one-cycle
// generation ticks, measures the edge-to-edge period, rejects edges that come
// too soon after an accepted one, and flags a source that has stopped.
module gen_tick_receiver
    import gol_timing_pkg::*;
#(
    parameter int TIMEOUT    = 1024,
    parameter int MIN_PERIOD = 2,
    parameter int CNT_W      = $clog2(TIMEOUT + 1)
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic                slow_clock,
    input  logic                run,
    input  logic                step,
    output logic                tick,
    output logic                gen_step,
    output logic [CNT_W-1:0]    period,
    output logic                period_valid,
    output logic                stalled,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);

    logic                raw_edge;
    rx_state_e           state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                armed_q;
    logic                armed_d;
    logic                tick_q;
    logic                gen_step_q;
    logic [CNT_W-1:0]    period_q;
    logic                period_valid_q;
    logic                stalled_q;
    logic [GLITCH_W-1:0] glitch_q;
    logic [GLITCH_W-1:0] glitch_d;
    logic                accept;
    logic                reject;
    logic                fire;

    sync_edge_detect u_sync (
        .clock_in (clock_in),
        .reset    (reset),
        .async_i  (slow_clock),
        .rise_o   (raw_edge)
    );

    // Classify the raw edge, work out gating and the next counter values.
    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        case (state_q)
            IDLE, STALLED: accept = raw_edge;
            MEASURE: begin
                if (raw_edge) begin
                    if (cnt_q >= MIN_C) begin
                        accept = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            default: begin
                accept = 1'b0;
                reject = 1'b0;
            end
        endcase

        // A step arriving with the edge counts, as does one armed earlier.
        fire = accept & (run | armed_q | step);

        // Firing in single-step mode consumes the arm, even a same-cycle step.
        armed_d = armed_q;
        if (fire && !run) begin
            armed_d = 1'b0;
        end else if (step) begin
            armed_d = 1'b1;
        end

        if (accept) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == TIMEOUT_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        glitch_d = reject ? glitch_inc(glitch_q) : glitch_q;
    end

    // Tracking FSM with all outputs registered.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            armed_q        <= 1'b0;
            tick_q         <= 1'b0;
            gen_step_q     <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b0;
            glitch_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            tick_q     <= accept;
            gen_step_q <= fire;
            glitch_q   <= glitch_d;
            case (state_q)
                IDLE: begin
                    // No earlier edge, so there is no period to latch yet.
                    if (accept) begin
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (accept) begin
                        period_q       <= cnt_q;
                        period_valid_q <= 1'b1;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_q        <= STALLED;
                        stalled_q      <= 1'b1;
                        period_valid_q <= 1'b0;
                    end
                end
                STALLED: begin
                    // The gap that ends here is meaningless; keep the old period.
                    if (accept) begin
                        state_q   <= MEASURE;
                        stalled_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tick         = tick_q;
    assign gen_step     = gen_step_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stalled      = stalled_q;
    assign glitch_count = glitch_q;

endmodule
